// File: rtl/vp_irq_ctl_pkg.sv
// Shared constants for the 1801VP1-033 serial-port interrupt controller:
// CSR addresses, default vectors, FSM state encoding and a bus-inversion helper.
package vp_irq_ctl_pkg;

    localparam logic [15:0] ADDR_RX_CSR = 16'o177560;
    localparam logic [15:0] ADDR_RX_DAT = 16'o177562;
    localparam logic [15:0] ADDR_TX_CSR = 16'o177564;
    localparam logic [15:0] ADDR_TX_DAT = 16'o177566;

    localparam logic [15:0] VEC_RX_DEF  = 16'o000060;
    localparam logic [15:0] VEC_TX_DEF  = 16'o000064;

    // Idle (deasserted) level of every active-low Q-bus control pin
    localparam logic        PIN_IDLE    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_HOLD  = 3'd2,
        ST_WAITI = 3'd3,
        ST_PASS  = 3'd4
    } irq_state_e;

    function automatic logic [15:0] bus_inv(input logic [15:0] v);
        return ~v;
    endfunction

endpackage

// File: rtl/vp_sync2.sv
// Two-flop synchroniser for an asynchronous Q-bus control pin.
module vp_sync2
    import vp_irq_ctl_pkg::*;
#(
    parameter logic RST_VAL = PIN_IDLE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // Shift the pin through two flops; reset parks both at the idle level
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ff_q <= {RST_VAL, RST_VAL};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/vp_irq_ctl.sv
// Q-bus interrupt controller for the 1801VP1-033 serial port in BPIC mode:
// latches RX/TX requests, drives nVIRQ, resolves IAKI/IAKO and returns the vector.
module vp_irq_ctl
    import vp_irq_ctl_pkg::*;
#(
    parameter logic [15:0] VEC_RX   = VEC_RX_DEF,
    parameter logic [15:0] VEC_TX   = VEC_TX_DEF,
    parameter int          RPLY_DLY = 2
) (
    input  logic        PIN_CLK,
    input  logic        PIN_nRST,
    input  logic        PIN_nINIT,
    input  logic        PIN_nSYNC,
    input  logic        PIN_nDIN,
    input  logic        PIN_nIAKI,
    input  logic        rx_ie,
    input  logic        rx_rdy,
    input  logic        tx_ie,
    input  logic        tx_rdy,
    output logic        PIN_nVIRQ,
    output logic        PIN_nIAKO,
    output logic        PIN_nRPLY,
    output logic [15:0] PIN_nAD,
    output logic        ad_oe,
    output logic        rx_ack,
    output logic        tx_ack
);

    localparam logic [2:0] CNT_LAST = 3'(RPLY_DLY - 1);

    logic        init_n, sync_n, din_n, iak_n;
    logic        rx_lvl, tx_lvl, iak_go;
    logic        rx_lvl_q, tx_lvl_q, rreq_q, treq_q, rreq_d, treq_d;
    irq_state_e  state_q, state_d;
    logic        chan_tx_q, chan_tx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        nvirq_q, niako_q, nrply_q, ad_oe_q, rx_ack_q, tx_ack_q;
    logic        niako_d, nrply_d, ad_oe_d, rx_ack_d, tx_ack_d;
    logic [15:0] nad_q, nad_d;

    vp_sync2 #(.RST_VAL(PIN_IDLE)) u_sync_init (.clk_i(PIN_CLK), .rst_ni(PIN_nRST), .d_i(PIN_nINIT), .q_o(init_n));
    vp_sync2 #(.RST_VAL(PIN_IDLE)) u_sync_sync (.clk_i(PIN_CLK), .rst_ni(PIN_nRST), .d_i(PIN_nSYNC), .q_o(sync_n));
    vp_sync2 #(.RST_VAL(PIN_IDLE)) u_sync_din  (.clk_i(PIN_CLK), .rst_ni(PIN_nRST), .d_i(PIN_nDIN),  .q_o(din_n));
    vp_sync2 #(.RST_VAL(PIN_IDLE)) u_sync_iak  (.clk_i(PIN_CLK), .rst_ni(PIN_nRST), .d_i(PIN_nIAKI), .q_o(iak_n));

    assign rx_lvl = rx_ie & rx_rdy;
    assign tx_lvl = tx_ie & tx_rdy;
    assign iak_go = ~iak_n & ~din_n & sync_n;

    // FSM state register; INIT behaves like reset but leaves the synchronisers alone
    always_ff @(posedge PIN_CLK) begin
        if (!PIN_nRST || !init_n) begin
            state_q   <= ST_IDLE;
            chan_tx_q <= 1'b0;
            cnt_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            chan_tx_q <= chan_tx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state: the serving channel is frozen on leaving IDLE; IAKI rising aborts a vector cycle
    always_comb begin
        state_d   = state_q;
        chan_tx_d = chan_tx_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (iak_go) begin
                    cnt_d = 3'd0;
                    if (rreq_q) begin
                        state_d   = ST_ACK;
                        chan_tx_d = 1'b0;
                    end else if (treq_q) begin
                        state_d   = ST_ACK;
                        chan_tx_d = 1'b1;
                    end else begin
                        state_d   = ST_PASS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (iak_n) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HOLD: begin
                if (iak_n) begin
                    state_d = ST_IDLE;
                end else if (din_n) begin
                    state_d = ST_WAITI;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_WAITI, ST_PASS: begin
                if (iak_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so the registered pins track the FSM without lag
    always_comb begin
        nrply_d  = (state_d != ST_HOLD);
        ad_oe_d  = (state_d == ST_ACK) || (state_d == ST_HOLD);
        niako_d  = (state_d != ST_PASS);
        rx_ack_d = (state_q == ST_HOLD) && (state_d == ST_WAITI) && !chan_tx_q;
        tx_ack_d = (state_q == ST_HOLD) && (state_d == ST_WAITI) &&  chan_tx_q;
        if (ad_oe_d) begin
            nad_d = bus_inv(chan_tx_d ? VEC_TX : VEC_RX);
        end else begin
            nad_d = 16'hFFFF;
        end
    end

    // Request flops: rising edge of ie&rdy sets, any clear condition overrides a set
    always_comb begin
        if (!rx_lvl || rx_ack_d) begin
            rreq_d = 1'b0;
        end else begin
            rreq_d = rreq_q | ~rx_lvl_q;
        end
        if (!tx_lvl || tx_ack_d) begin
            treq_d = 1'b0;
        end else begin
            treq_d = treq_q | ~tx_lvl_q;
        end
    end

    // Request flops, edge history and registered bus outputs
    always_ff @(posedge PIN_CLK) begin
        if (!PIN_nRST || !init_n) begin
            rx_lvl_q <= 1'b0;
            tx_lvl_q <= 1'b0;
            rreq_q   <= 1'b0;
            treq_q   <= 1'b0;
            nvirq_q  <= 1'b1;
            niako_q  <= 1'b1;
            nrply_q  <= 1'b1;
            ad_oe_q  <= 1'b0;
            nad_q    <= 16'hFFFF;
            rx_ack_q <= 1'b0;
            tx_ack_q <= 1'b0;
        end else begin
            rx_lvl_q <= rx_lvl;
            tx_lvl_q <= tx_lvl;
            rreq_q   <= rreq_d;
            treq_q   <= treq_d;
            nvirq_q  <= ~(rreq_q | treq_q);
            niako_q  <= niako_d;
            nrply_q  <= nrply_d;
            ad_oe_q  <= ad_oe_d;
            nad_q    <= nad_d;
            rx_ack_q <= rx_ack_d;
            tx_ack_q <= tx_ack_d;
        end
    end

    assign PIN_nVIRQ = nvirq_q;
    assign PIN_nIAKO = niako_q;
    assign PIN_nRPLY = nrply_q;
    assign PIN_nAD   = nad_q;
    assign ad_oe     = ad_oe_q;
    assign rx_ack    = rx_ack_q;
    assign tx_ack    = tx_ack_q;

endmodule

// File: doc/vp_irq_ctl.md
Name: vp_irq_ctl

Overview:
Clocked Q-bus interrupt controller for the 1801VP1-033 serial-port function in BPIC mode.
- Latches the receiver and transmitter interrupt requests and drives nVIRQ.
- Resolves the IAKI/IAKO daisy chain and places the winning channel's vector on nAD during the interrupt-acknowledge nDIN cycle.
- Sits between the RX/TX CSR logic (which supplies ready and interrupt-enable levels) and the Q-bus pins.

Parameters:
VEC_RX, 16'o000060, vector returned for a receiver interrupt
VEC_TX, 16'o000064, vector returned for a transmitter interrupt
RPLY_DLY, 2, clocks from vector driven on nAD to nRPLY asserted (1..7)

Ports:
PIN_CLK  in  1  system clock
PIN_nRST  in  1  synchronous reset, active low
PIN_nINIT  in  1  Q-bus init, active low, asynchronous to PIN_CLK
PIN_nSYNC  in  1  Q-bus SYNC, active low, asynchronous
PIN_nDIN  in  1  Q-bus DIN, active low, asynchronous
PIN_nIAKI  in  1  daisy-chain acknowledge in, active low, asynchronous
rx_ie  in  1  RX CSR bit 6 (interrupt enable)
rx_rdy  in  1  RX CSR bit 7 (done)
tx_ie  in  1  TX CSR bit 6
tx_rdy  in  1  TX CSR bit 7 (ready)
PIN_nVIRQ  out  1  interrupt request, active low
PIN_nIAKO  out  1  daisy-chain acknowledge out, active low
PIN_nRPLY  out  1  reply, active low
PIN_nAD  out  16  inverted vector, valid when ad_oe=1
ad_oe  out  1  nAD output enable
rx_ack  out  1  one-clock pulse: RX vector accepted
tx_ack  out  1  one-clock pulse: TX vector accepted

Behaviour:
Reset
- PIN_nRST sampled low: nVIRQ=1, nIAKO=1, nRPLY=1, ad_oe=0, nAD=16'hFFFF, rx_ack=tx_ack=0.
- Request flops clear; FSM goes to IDLE.
- Reset mid-acknowledge aborts the cycle with no ack pulse.

Synchronisers and init
- nINIT, nSYNC, nDIN, nIAKI each pass through a 2-flop synchroniser; all decisions use the synchronised values.
- Synchronised nINIT low has the same effect as reset, except the synchronisers keep running.

Request flops (one per channel)
- Set on the 0->1 transition of (ie & rdy), detected against the previous clock's value.
- Cleared when ie=0, rdy=0, INIT is active, or on the channel's ack pulse.
- If set and clear occur in the same clock, clear wins.
- ie going 1 with rdy already 1 counts as a transition and sets the request.
- nVIRQ = ~(rreq | treq), registered; updated one clock after a request flop changes.

FSM states
- IDLE: if nIAKI=0 and nDIN=0 and nSYNC=1:
  - rreq set -> ACK with channel RX;
  - else treq set -> ACK with channel TX;
  - else -> PASS.
  - The channel is latched here; later request changes do not alter the cycle.
- ACK: ad_oe=1, nAD=~vector. Count RPLY_DLY clocks, then nRPLY=0 -> HOLD.
- HOLD: keep vector and nRPLY low until nDIN=1. Then:
  - nRPLY=1, ad_oe=0;
  - pulse the latched channel's ack for one clock;
  - clear that channel's request flop;
  - -> WAITI.
- WAITI: wait for nIAKI=1, then -> IDLE. A new acknowledge needs nIAKI to rise first.
- PASS: nIAKO=0 while nIAKI=0; on nIAKI=1, nIAKO=1 in the same clock, then -> IDLE.
  - A request that sets during PASS is not served in this cycle; it is served in the next acknowledge.

Other rules
- If nIAKI rises during ACK or HOLD, abort: release nRPLY and ad_oe, no ack pulse, request stays set, -> IDLE.
- nIAKO is never asserted in ACK, HOLD or WAITI.
- RX has fixed priority over TX. With both pending, two successive acknowledge cycles return 060 and then 064.

Decomposition:
- Shared package: Q-bus address constants (RX_CSR 177560, RX_DAT 177562, TX_CSR 177564, TX_DAT 177566), default vectors 060/064, and the FSM state encoding (IDLE, ACK, HOLD, WAITI, PASS; 3-bit).
- One sub-module, vp_sync2: a 2-flop synchroniser with a reset value parameter, instanced four times.

Test Plan:
1. Reset: hold PIN_nRST=0 for 3 clocks with tx_ie=tx_rdy=1 -> all outputs at reset values. After release, nVIRQ falls within 2 clocks (edge seen as ie&rdy 0->1).
2. TX only: tx_ie=1, tx_rdy 0->1; run an IAKI+DIN cycle -> nAD=~000064, ad_oe=1, nRPLY low RPLY_DLY+1..+3 clocks after nDIN, tx_ack pulses once, nVIRQ returns to 1, nIAKO stays 1.
3. Both pending: rx_ie=rx_rdy=tx_ie=tx_rdy=1 -> first acknowledge returns 000060 with rx_ack; nVIRQ stays 0; second acknowledge returns 000064 with tx_ack.
4. Pass-through: no requests, nIAKI low with nDIN low -> nIAKO low within 3 clocks and back high within 3 clocks of nIAKI high; nRPLY stays 1 and ad_oe stays 0.
5. Disable and init: rx request pending, then rx_ie=0 -> nVIRQ=1 and a following acknowledge passes (nIAKO low). Re-set the request, pulse nINIT low for 4 clocks -> request cleared.
6. Abort: raise nIAKI during HOLD -> nRPLY and ad_oe release, no ack pulse, nVIRQ still 0, and the next acknowledge returns the same vector.
